balance_display_mux: RTL and testbench

BALANCE_DISPLAY_MUX -- requirements
Module: balance_display_mux

---
 rtl/balance_display_mux.sv | 213 +++++++++++++++++++++
 tb/tb_balance_display_mux.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/balance_display_mux.sv
// Balance display multiplexer.
//
// Selects one of NCH unsigned balance channels and shows it in hex on an
// 8-digit, time-multiplexed, active-low 7-segment display. The channel is
// stepped by debounced up/down buttons or by an optional auto-scroll timer.
// The displayed value comes from a shadow register, so a whole frame always
// shows one coherent value.
//
// Ports:
//   clk          system clock, all state on rising edge
//   rst_n        asynchronous active-low reset
//   btn_up_i     debounced level, rising edge selects the next channel
//   btn_down_i   debounced level, rising edge selects the previous channel
//   mode_auto_i  1 = auto-scroll through the channels
//   balances_i   channel k at bits [k*DW +: DW]
//   an_o         digit enables, active-low, one-hot or all-high
//   seg_o        segments {g,f,e,d,c,b,a}, active-low
//   chan_sel_o   currently displayed channel index
module balance_display_mux #(
  parameter int unsigned NCH      = 5,
  parameter int unsigned DW       = 32,
  parameter int unsigned SCAN_DIV = 100000,
  parameter int unsigned AUTO_DIV = 200000000,
  parameter int unsigned LZB      = 1,
  localparam int unsigned CW      = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                btn_up_i,
  input  logic                btn_down_i,
  input  logic                mode_auto_i,
  input  logic [NCH*DW-1:0]   balances_i,
  output logic [7:0]          an_o,
  output logic [6:0]          seg_o,
  output logic [CW-1:0]       chan_sel_o
);

  localparam int unsigned NDIG = (DW + 3) / 4;
  localparam int unsigned SW   = $clog2(SCAN_DIV);
  localparam int unsigned AW   = $clog2(AUTO_DIV);

  localparam logic [CW-1:0] ChanMax  = CW'(NCH - 1);
  localparam logic [SW-1:0] ScanLast = SW'(SCAN_DIV - 1);
  localparam logic [AW-1:0] AutoLast = AW'(AUTO_DIV - 1);

  // Hex digit to active-low {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex_seg(input logic [3:0] nib);
    logic [6:0] s;
    unique case (nib)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      4'hF: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic          btn_up_q, btn_down_q;
  logic [CW-1:0] chan_q, chan_d;
  logic [AW-1:0] auto_q, auto_d;
  logic          reload_q, reload_d;
  logic [SW-1:0] scan_q, scan_d;
  logic [2:0]    dig_q, dig_d;
  logic [DW-1:0] shadow_q, shadow_d;
  logic [7:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;

  // ---------------------------------------------------------------------------
  // Channel selection
  // ---------------------------------------------------------------------------
  logic          up_edge, down_edge, up_step, down_step, auto_tick;
  logic [CW-1:0] chan_inc, chan_dec;

  always_comb begin
    up_edge   = btn_up_i & ~btn_up_q;
    down_edge = btn_down_i & ~btn_down_q;
    // Simultaneous up and down edges cancel each other out.
    up_step   = up_edge & ~down_edge;
    down_step = down_edge & ~up_edge;
    auto_tick = mode_auto_i && (auto_q == AutoLast);

    chan_inc = (chan_q == ChanMax) ? '0 : chan_q + CW'(1);
    chan_dec = (chan_q == '0) ? ChanMax : chan_q - CW'(1);

    // A tick together with an up step counts once; with a down step they
    // cancel.
    chan_d = chan_q;
    if (up_step || (auto_tick && !down_step)) begin
      chan_d = chan_inc;
    end else if (down_step && !auto_tick) begin
      chan_d = chan_dec;
    end

    // Any accepted button step restarts the auto-scroll interval.
    auto_d = auto_q + AW'(1);
    if (up_step || down_step || !mode_auto_i || auto_tick) begin
      auto_d = '0;
    end

    reload_d = (chan_d != chan_q);
  end

  // ---------------------------------------------------------------------------
  // Scan and shadow register
  // ---------------------------------------------------------------------------
  logic [DW-1:0] chan_bal;

  always_comb begin
    chan_bal = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      if (chan_q == CW'(k)) begin
        chan_bal = balances_i[k*DW +: DW];
      end
    end
  end

  always_comb begin
    scan_d   = scan_q;
    dig_d    = dig_q;
    shadow_d = shadow_q;
    if (reload_q) begin
      // New channel (or first cycle after reset): restart the frame on it.
      scan_d   = '0;
      dig_d    = '0;
      shadow_d = chan_bal;
    end else if (scan_q == ScanLast) begin
      scan_d = '0;
      dig_d  = dig_q + 3'd1;
      // Refresh the shadow only at frame boundaries so a frame never tears.
      if (dig_q == 3'd7) begin
        shadow_d = chan_bal;
      end
    end else begin
      scan_d = scan_q + SW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Digit decode
  // ---------------------------------------------------------------------------
  logic [31:0] shadow_ext;
  logic [3:0]  nibble;
  logic        upper_zero;
  logic        blank;

  always_comb begin
    shadow_ext           = '0;
    shadow_ext[DW-1:0]   = shadow_q;
    nibble               = shadow_ext[{dig_q, 2'b00} +: 4];
    // All nibbles at or above the current digit are zero.
    upper_zero           = ((shadow_ext >> {dig_q, 2'b00}) == 32'd0);
    blank = ({29'd0, dig_q} >= NDIG) ||
            ((LZB != 0) && (dig_q != 3'd0) && upper_zero);

    an_d  = 8'hFF;
    seg_d = 7'h7F;
    if (!blank) begin
      an_d  = ~(8'd1 << dig_q);
      seg_d = hex_seg(nibble);
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // Buttons reset high so a button held through reset gives no edge.
      btn_up_q   <= 1'b1;
      btn_down_q <= 1'b1;
      chan_q     <= '0;
      auto_q     <= '0;
      // Forces a shadow load from channel 0 right after reset release.
      reload_q   <= 1'b1;
      scan_q     <= '0;
      dig_q      <= '0;
      shadow_q   <= '0;
      an_q       <= 8'hFF;
      seg_q      <= 7'h7F;
    end else begin
      btn_up_q   <= btn_up_i;
      btn_down_q <= btn_down_i;
      chan_q     <= chan_d;
      auto_q     <= auto_d;
      reload_q   <= reload_d;
      scan_q     <= scan_d;
      dig_q      <= dig_d;
      shadow_q   <= shadow_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
    end
  end

  assign an_o       = an_q;
  assign seg_o      = seg_q;
  assign chan_sel_o = chan_q;

endmodule

// File: tb/tb_balance_display_mux.sv
module tb_balance_display_mux;

  localparam int unsigned NCH = 5;
  localparam int unsigned DW  = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              btn_up = 1'b0;
  logic              btn_down = 1'b0;
  logic              mode_auto = 1'b0;
  logic [NCH*DW-1:0] balances;
  logic [7:0]        an;
  logic [6:0]        seg;
  logic [2:0]        chan_sel;

  int n_vec = 0;
  int n_err = 0;

  balance_display_mux #(
    .NCH      (NCH),
    .DW       (DW),
    .SCAN_DIV (4),
    .AUTO_DIV (20),
    .LZB      (1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_up_i    (btn_up),
    .btn_down_i  (btn_down),
    .mode_auto_i (mode_auto),
    .balances_i  (balances),
    .an_o        (an),
    .seg_o       (seg),
    .chan_sel_o  (chan_sel)
  );

  always #5 clk = ~clk;

  // Reset released just after a falling edge; the next rising edge is P1.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_vec++;
    if (an !== 8'hFF) begin n_err++; $display("FAIL reset_an got %h want ff", an); end
    n_vec++;
    if (seg !== 7'h7F) begin n_err++; $display("FAIL reset_seg got %h want 7f", seg); end
    n_vec++;
    if (chan_sel !== 3'd0) begin n_err++; $display("FAIL reset_chan got %0d want 0", chan_sel); end
  endtask

  // ch0 = 0000_12AF: digits F,A,2,1 then four blanks, four cycles each.
  task automatic test_scan();
    logic [7:0] exp_an [8];
    logic [6:0] exp_seg [8];
    exp_an  = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    exp_seg = '{7'h0E, 7'h08, 7'h24, 7'h79, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
    do_reset();
    @(negedge clk);  // P1
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);  // P2+i
      n_vec++;
      if (an !== exp_an[i/4] || seg !== exp_seg[i/4]) begin
        n_err++;
        $display("FAIL scan_slot%0d got an=%h seg=%h want an=%h seg=%h",
                 i/4, an, seg, exp_an[i/4], exp_seg[i/4]);
      end
    end
    @(negedge clk);  // second frame, digit 0
    n_vec++;
    if (an !== 8'hFE || seg !== 7'h0E) begin
      n_err++; $display("FAIL scan_wrap got an=%h seg=%h want an=fe seg=0e", an, seg);
    end
  endtask

  task automatic test_buttons();
    logic [2:0] exp_up [5];
    exp_up = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      btn_up = 1'b1;
      @(negedge clk);
      n_vec++;
      if (chan_sel !== exp_up[i]) begin
        n_err++; $display("FAIL up_step%0d got %0d want %0d", i, chan_sel, exp_up[i]);
      end
      btn_up = 1'b0;
    end
    @(negedge clk);
    btn_down = 1'b1;
    @(negedge clk);
    n_vec++;
    if (chan_sel !== 3'd4) begin
      n_err++; $display("FAIL down_wrap got %0d want 4", chan_sel);
    end
    btn_down = 1'b0;
  endtask

  // ch1 = 0010_0000: inner zeros shown, only digits 6 and 7 blanked; the
  // frame restarts at digit 0 right after the channel change.
  task automatic test_chan_load();
    logic [7:0] exp_an [8];
    logic [6:0] exp_seg [8];
    exp_an  = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hFF, 8'hFF};
    exp_seg = '{7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h79, 7'h7F, 7'h7F};
    do_reset();
    repeat (6) @(negedge clk);
    btn_up = 1'b1;
    @(negedge clk);  // E
    btn_up = 1'b0;
    n_vec++;
    if (chan_sel !== 3'd1) begin
      n_err++; $display("FAIL load_chan got %0d want 1", chan_sel);
    end
    @(negedge clk);  // E1
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);  // E2+i
      n_vec++;
      if (an !== exp_an[i/4] || seg !== exp_seg[i/4]) begin
        n_err++;
        $display("FAIL load_slot%0d got an=%h seg=%h want an=%h seg=%h",
                 i/4, an, seg, exp_an[i/4], exp_seg[i/4]);
      end
    end
  endtask

  task automatic test_auto_scroll();
    do_reset();
    @(negedge clk);
    mode_auto = 1'b1;
    repeat (19) @(negedge clk);  // Q19
    n_vec++;
    if (chan_sel !== 3'd0) begin n_err++; $display("FAIL auto_q19 got %0d want 0", chan_sel); end
    @(negedge clk);  // Q20
    n_vec++;
    if (chan_sel !== 3'd1) begin n_err++; $display("FAIL auto_q20 got %0d want 1", chan_sel); end
    repeat (19) @(negedge clk);  // Q39
    n_vec++;
    if (chan_sel !== 3'd1) begin n_err++; $display("FAIL auto_q39 got %0d want 1", chan_sel); end
    @(negedge clk);  // Q40
    n_vec++;
    if (chan_sel !== 3'd2) begin n_err++; $display("FAIL auto_q40 got %0d want 2", chan_sel); end
    repeat (10) @(negedge clk);  // Q50
    btn_up = 1'b1;
    @(negedge clk);  // Q51
    btn_up = 1'b0;
    n_vec++;
    if (chan_sel !== 3'd3) begin n_err++; $display("FAIL auto_btn got %0d want 3", chan_sel); end
    repeat (19) @(negedge clk);  // Q70
    n_vec++;
    if (chan_sel !== 3'd3) begin n_err++; $display("FAIL auto_restart got %0d want 3", chan_sel); end
    @(negedge clk);  // Q71
    n_vec++;
    if (chan_sel !== 3'd4) begin n_err++; $display("FAIL auto_after_btn got %0d want 4", chan_sel); end
  endtask

  // Continues the auto timeline of test_auto_scroll (counter 0 after Q71).
  task automatic test_both_and_tick();
    repeat (4) @(negedge clk);  // Q75
    btn_up   = 1'b1;
    btn_down = 1'b1;
    @(negedge clk);  // Q76
    btn_up   = 1'b0;
    btn_down = 1'b0;
    n_vec++;
    if (chan_sel !== 3'd4) begin n_err++; $display("FAIL both_edges got %0d want 4", chan_sel); end
    repeat (14) @(negedge clk);  // Q90
    n_vec++;
    if (chan_sel !== 3'd4) begin n_err++; $display("FAIL both_q90 got %0d want 4", chan_sel); end
    @(negedge clk);  // Q91: counter was not restarted by the cancelled edges
    n_vec++;
    if (chan_sel !== 3'd0) begin n_err++; $display("FAIL both_q91 got %0d want 0", chan_sel); end
    repeat (19) @(negedge clk);  // Q110
    btn_down = 1'b1;
    @(negedge clk);  // Q111: tick and down edge cancel
    btn_down = 1'b0;
    n_vec++;
    if (chan_sel !== 3'd0) begin n_err++; $display("FAIL tick_down got %0d want 0", chan_sel); end
    repeat (19) @(negedge clk);  // Q130
    n_vec++;
    if (chan_sel !== 3'd0) begin n_err++; $display("FAIL tick_down_q130 got %0d want 0", chan_sel); end
    @(negedge clk);  // Q131
    n_vec++;
    if (chan_sel !== 3'd1) begin n_err++; $display("FAIL tick_down_q131 got %0d want 1", chan_sel); end
    mode_auto = 1'b0;
  endtask

  task automatic test_midframe();
    balances[0 +: 32] = 32'h0000_12AF;
    do_reset();
    @(negedge clk);               // P1
    repeat (13) @(negedge clk);   // P14, digit 3
    n_vec++;
    if (an !== 8'hF7 || seg !== 7'h79) begin
      n_err++; $display("FAIL mid_before got an=%h seg=%h want an=f7 seg=79", an, seg);
    end
    balances[0 +: 32] = 32'h0000_ABCD;
    @(negedge clk);               // P15
    n_vec++;
    if (an !== 8'hF7 || seg !== 7'h79) begin
      n_err++; $display("FAIL mid_hold got an=%h seg=%h want an=f7 seg=79", an, seg);
    end
    repeat (3) @(negedge clk);    // P18, digit 4
    n_vec++;
    if (an !== 8'hFF || seg !== 7'h7F) begin
      n_err++; $display("FAIL mid_blank got an=%h seg=%h want an=ff seg=7f", an, seg);
    end
    repeat (16) @(negedge clk);   // P34, new frame digit 0
    n_vec++;
    if (an !== 8'hFE || seg !== 7'h21) begin
      n_err++; $display("FAIL mid_new_d0 got an=%h seg=%h want an=fe seg=21", an, seg);
    end
    repeat (4) @(negedge clk);
    n_vec++;
    if (an !== 8'hFD || seg !== 7'h46) begin
      n_err++; $display("FAIL mid_new_d1 got an=%h seg=%h want an=fd seg=46", an, seg);
    end
    repeat (4) @(negedge clk);
    n_vec++;
    if (an !== 8'hFB || seg !== 7'h03) begin
      n_err++; $display("FAIL mid_new_d2 got an=%h seg=%h want an=fb seg=03", an, seg);
    end
    repeat (4) @(negedge clk);
    n_vec++;
    if (an !== 8'hF7 || seg !== 7'h08) begin
      n_err++; $display("FAIL mid_new_d3 got an=%h seg=%h want an=f7 seg=08", an, seg);
    end
  endtask

  task automatic test_reset_held();
    balances[0 +: 32] = 32'h0000_12AF;
    do_reset();
    @(negedge clk);               // P1
    btn_up = 1'b1;
    @(negedge clk);               // E: channel 1
    btn_up = 1'b0;
    repeat (10) @(negedge clk);   // E10, digit 2 of ch1
    n_vec++;
    if (an !== 8'hFB || seg !== 7'h40 || chan_sel !== 3'd1) begin
      n_err++;
      $display("FAIL held_pre got an=%h seg=%h chan=%0d want an=fb seg=40 chan=1",
               an, seg, chan_sel);
    end
    #2;
    rst_n  = 1'b0;
    btn_up = 1'b1;
    #1;
    n_vec++;
    if (an !== 8'hFF || seg !== 7'h7F || chan_sel !== 3'd0) begin
      n_err++;
      $display("FAIL held_async got an=%h seg=%h chan=%0d want an=ff seg=7f chan=0",
               an, seg, chan_sel);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);    // R2: shadow already loaded from ch0
    n_vec++;
    if (an !== 8'hFE || seg !== 7'h0E || chan_sel !== 3'd0) begin
      n_err++;
      $display("FAIL held_release got an=%h seg=%h chan=%0d want an=fe seg=0e chan=0",
               an, seg, chan_sel);
    end
    repeat (5) @(negedge clk);
    n_vec++;
    if (chan_sel !== 3'd0) begin n_err++; $display("FAIL held_nostep got %0d want 0", chan_sel); end
    btn_up = 1'b0;
    @(negedge clk);
    btn_up = 1'b1;
    @(negedge clk);
    btn_up = 1'b0;
    n_vec++;
    if (chan_sel !== 3'd1) begin n_err++; $display("FAIL held_repress got %0d want 1", chan_sel); end
  endtask

  initial begin
    balances = '0;
    balances[0*32 +: 32] = 32'h0000_12AF;
    balances[1*32 +: 32] = 32'h0010_0000;
    balances[2*32 +: 32] = 32'hDEAD_BEEF;
    balances[3*32 +: 32] = 32'h0000_0007;
    balances[4*32 +: 32] = 32'h1234_5678;

    test_reset();
    rst_n = 1'b1;
    test_scan();
    test_buttons();
    test_chan_load();
    test_auto_scroll();
    test_both_and_tick();
    test_midframe();
    test_reset_held();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
